reg_bank4_scan: RTL and testbench

//  Four-entry 16-bit mailbox that feeds Mux4Way16 directly upstream.

---
 rtl/reg_bank4_scan_if.sv | 25 ++
 rtl/reg_bank4_scan.sv | 97 +++++++++
 tb/tb_reg_bank4_scan.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_bank4_scan_if.sv
// Producer/consumer bundle for the four-entry scan mailbox.
// The master drives writes and out_ready; the slave returns the entries, select and status.
interface reg_bank4_scan_if #(
   parameter int WIDTH = 16
);
   logic             wr_en;
   logic [1:0]       wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic             out_ready;
   logic [WIDTH-1:0] a, b, c, d;
   logic [1:0]       sel;
   logic             out_valid;
   logic [3:0]       pending;
   logic             wr_ovf;

   modport master (
      output wr_en, wr_addr, wr_data, out_ready,
      input  a, b, c, d, sel, out_valid, pending, wr_ovf
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, out_ready,
      output a, b, c, d, sel, out_valid, pending, wr_ovf
   );
endinterface

// File: rtl/reg_bank4_scan.sv
// Four-entry mailbox whose round-robin scanner steers a downstream Mux4Way16.
// Each entry holds data plus a pending flag; a write wins over a same-edge consume.
module reg_bank4_entry #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             we,
   input  logic             clr,
   input  logic [WIDTH-1:0] wd,
   output logic [WIDTH-1:0] q,
   output logic             pend
);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q    <= INIT;
         pend <= 1'b0;
      end else begin
         if (we) q <= wd;
         if (we)       pend <= 1'b1;
         else if (clr) pend <= 1'b0;
      end
   end
endmodule

module reg_bank4_scan #(
   parameter int               WIDTH = 16,
   parameter logic [WIDTH-1:0] INIT  = '0
) (
   input  logic            clk,
   input  logic            reset,
   reg_bank4_scan_if.slave bus
);
   localparam int NUM_LANES = 4;

   logic [NUM_LANES-1:0][WIDTH-1:0] ent;
   logic [NUM_LANES-1:0]            pend;
   logic [NUM_LANES-1:0]            we;
   logic [NUM_LANES-1:0]            clr;
   logic [NUM_LANES-1:0]            scan_v;
   logic [1:0]                      sel, sel_nxt;
   logic                            vld, consume, ovf;

   assign vld     = pend[sel];
   assign consume = vld && bus.out_ready;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_ent
      assign we[i]  = bus.wr_en && (bus.wr_addr == 2'(i));
      assign clr[i] = consume && (sel == 2'(i));
      reg_bank4_entry #(.WIDTH(WIDTH), .INIT(INIT)) u_ent (
         .clk  (clk),
         .reset(reset),
         .we   (we[i]),
         .clr  (clr[i]),
         .wd   (bus.wr_data),
         .q    (ent[i]),
         .pend (pend[i])
      );
   end

   // Scan the registered flags minus the entry leaving this edge; a same-edge
   // write is picked up by the idle scan one cycle later. Reverse loop so the
   // nearest candidate after sel wins.
   always_comb begin
      scan_v = pend;
      if (consume) scan_v[sel] = 1'b0;
      sel_nxt = sel;
      if (consume) begin
         sel_nxt = sel + 2'd1;
         for (int k = NUM_LANES; k >= 1; k--)
            if (scan_v[sel + 2'(k)]) sel_nxt = sel + 2'(k);
      end else if (!vld && (|scan_v)) begin
         for (int k = NUM_LANES; k >= 1; k--)
            if (scan_v[sel + 2'(k)]) sel_nxt = sel + 2'(k);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel <= 2'd0;
         ovf <= 1'b0;
      end else begin
         sel <= sel_nxt;
         ovf <= bus.wr_en && pend[bus.wr_addr] && !(consume && (bus.wr_addr == sel));
      end
   end

   assign bus.a         = ent[0];
   assign bus.b         = ent[1];
   assign bus.c         = ent[2];
   assign bus.d         = ent[3];
   assign bus.sel       = sel;
   assign bus.out_valid = vld;
   assign bus.pending   = pend;
   assign bus.wr_ovf    = ovf;
endmodule

// File: tb/tb_reg_bank4_scan.sv
// Scoreboard bench for reg_bank4_scan: directed scenarios then random traffic,
// checked against an array-based mailbox model.
module tb_reg_bank4_scan;
   localparam int W = 16;

   typedef struct packed {
      logic [3:0][W-1:0] ent;
      logic [3:0]        pend;
      logic [1:0]        sel;
      logic              ovf;
   } st_t;

   typedef struct packed {
      logic [1:0]   idx;
      logic [W-1:0] data;
   } acc_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   reg_bank4_scan_if #(.WIDTH(W)) bus();
   reg_bank4_scan #(.WIDTH(W), .INIT(16'h0)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_err = 0;
   st_t  st_q[$];
   acc_t acc_q[$];

   logic [W-1:0] m_mem[4];
   bit           m_pend[4];
   int           m_sel;
   bit           m_ovf;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_mem[i]  = 16'h0;
         m_pend[i] = 1'b0;
      end
      m_sel = 0;
      m_ovf = 1'b0;
   endtask

   function automatic st_t model_state();
      st_t s;
      for (int i = 0; i < 4; i++) begin
         s.ent[i]  = m_mem[i];
         s.pend[i] = m_pend[i];
      end
      s.sel = 2'(m_sel);
      s.ovf = m_ovf;
      return s;
   endfunction

   // One clock of stimulus; the model predicts the accept (if any) and the post-edge state.
   task automatic cyc(logic we, logic [1:0] wa, logic [W-1:0] wd, logic rdy);
      bit   v, acc, found;
      bit   q[4];
      int   ns;
      acc_t e;
      @(negedge clk);
      bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd; bus.out_ready = rdy;
      v   = m_pend[m_sel];
      acc = v && rdy;
      if (acc) begin
         e.idx  = 2'(m_sel);
         e.data = m_mem[m_sel];
         acc_q.push_back(e);
      end
      m_ovf = we && m_pend[wa] && !(acc && int'(wa) == m_sel);
      q = m_pend;
      if (acc) q[m_sel] = 1'b0;
      ns = m_sel;
      found = 1'b0;
      if (acc || (!v && (q[0] || q[1] || q[2] || q[3]))) begin
         for (int k = 1; k <= 4; k++)
            if (!found && q[(m_sel + k) % 4]) begin
               ns = (m_sel + k) % 4;
               found = 1'b1;
            end
         if (!found) ns = (m_sel + 1) % 4;
      end
      if (acc) m_pend[m_sel] = 1'b0;
      if (we) begin
         m_pend[wa] = 1'b1;
         m_mem[wa]  = wd;
      end
      m_sel = ns;
      st_q.push_back(model_state());
   endtask

   task automatic chk_reset_state(string tag);
      chk({tag, "_abcd"}, {bus.d, bus.c, bus.b, bus.a}, 64'h0);
      chk({tag, "_pending"}, 64'(bus.pending), 64'h0);
      chk({tag, "_sel"}, 64'(bus.sel), 64'h0);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'h0);
      chk({tag, "_wr_ovf"}, 64'(bus.wr_ovf), 64'h0);
   endtask

   // Monitor: accepted words at the handshake, full state after each edge.
   initial begin
      acc_t e;
      st_t  s;
      logic [W-1:0] mux;
      forever begin
         @(negedge clk); #2;
         if (st_q.size() > 0 && bus.out_valid && bus.out_ready) begin
            case (bus.sel)
               2'd0:    mux = bus.a;
               2'd1:    mux = bus.b;
               2'd2:    mux = bus.c;
               default: mux = bus.d;
            endcase
            if (acc_q.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL accept_unexpected: got sel=%0d data=%0h want no accept", bus.sel, mux);
            end else begin
               e = acc_q.pop_front();
               chk("acc_sel", 64'(bus.sel), 64'(e.idx));
               chk("acc_data", 64'(mux), 64'(e.data));
            end
         end
         @(posedge clk); #1;
         if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("abcd", {bus.d, bus.c, bus.b, bus.a}, s.ent);
            chk("pending", 64'(bus.pending), 64'(s.pend));
            chk("sel", 64'(bus.sel), 64'(s.sel));
            chk("wr_ovf", 64'(bus.wr_ovf), 64'(s.ovf));
            chk("out_valid", 64'(bus.out_valid), 64'(s.pend[s.sel]));
         end
      end
   end

   initial begin
      bus.wr_en = 1'b0; bus.wr_addr = 2'd0; bus.wr_data = '0; bus.out_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk_reset_state("reset");
      reset = 1'b0;
      repeat (3) cyc(1'b0, 2'd0, 16'h0, 1'b0);

      // Single write to c, then consume it
      cyc(1'b1, 2'd2, 16'h1234, 1'b0);
      cyc(1'b0, 2'd0, 16'h0, 1'b0);
      cyc(1'b0, 2'd0, 16'h0, 1'b1);

      // Fill all four, then drain back-to-back
      for (int i = 0; i < 4; i++) cyc(1'b1, 2'(i), 16'(i + 1), 1'b0);
      repeat (5) cyc(1'b0, 2'd0, 16'h0, 1'b1);

      // Overwrite before consume
      cyc(1'b1, 2'd1, 16'h5, 1'b0);
      cyc(1'b1, 2'd1, 16'h6, 1'b0);
      cyc(1'b0, 2'd0, 16'h0, 1'b0);
      repeat (2) cyc(1'b0, 2'd0, 16'h0, 1'b1);

      // Consume b while rewriting b on the same edge
      cyc(1'b1, 2'd1, 16'h8, 1'b0);
      repeat (2) cyc(1'b0, 2'd0, 16'h0, 1'b0);
      cyc(1'b1, 2'd1, 16'h7, 1'b1);
      repeat (4) cyc(1'b0, 2'd0, 16'h0, 1'b1);

      // Random traffic
      for (int n = 0; n < 600; n++)
         cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
             1'($urandom_range(0, 9) < 6));
      repeat (8) cyc(1'b0, 2'd0, 16'h0, 1'b1);

      // Reset in the middle of a stalled handshake
      cyc(1'b1, 2'd3, 16'hbeef, 1'b0);
      repeat (2) cyc(1'b0, 2'd0, 16'h0, 1'b0);
      @(negedge clk); #3;
      chk("pre_reset_valid", 64'(bus.out_valid), 64'(m_pend[m_sel]));
      reset = 1'b1;
      #1;
      chk_reset_state("async_reset");
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) cyc(1'b0, 2'd0, 16'h0, 1'b1);
      cyc(1'b1, 2'd0, 16'h00aa, 1'b0);
      repeat (2) cyc(1'b0, 2'd0, 16'h0, 1'b1);

      @(posedge clk); #3;
      chk("acc_q_drained", 64'(acc_q.size()), 64'h0);
      chk("st_q_drained", 64'(st_q.size()), 64'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule
